// File: rtl/risc_v.sv
// rtl/risc_v.sv - single-cycle RV32I-subset core with local register file and data memory
//
// Ports:
//   clk        system clock, all state commits on the rising edge
//   rst        asynchronous active-low reset (clears pc, registers and data memory)
//   mem_input  256-word instruction image, word i at byte address 4*i
//
// Build option: RISC_V_FULL_BRANCH_EN adds BNE/BLT/BGE/BLTU/BGEU decode;
// without it only BEQ is a branch and other branch funct3 values retire as NOPs.
module risc_v (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_input [0:255]
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [0:31];
    logic [31:0] dmem_q [0:255];

    logic [31:0] instr;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] pc_plus4, load_addr, store_addr;
    logic        br_taken;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        dm_we;
    logic [7:0]  dm_waddr;
    logic [31:0] dm_wdata;

    assign instr  = mem_input[pc_q[9:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // x0 is never written, so a plain array read already returns 0 for it.
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    assign pc_plus4   = pc_q + 32'd4;
    assign load_addr  = rs1_val + imm_i;
    assign store_addr = rs1_val + imm_s;

    // Only the word index of data addresses matters; the rest is intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{load_addr[31:10], load_addr[1:0],
                                store_addr[31:10], store_addr[1:0]};

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
`ifdef RISC_V_FULL_BRANCH_EN
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
`endif
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d     = pc_plus4;
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = '0;
        dm_we    = 1'b0;
        dm_waddr = store_addr[9:2];
        dm_wdata = rs2_val;
        case (opcode)
            OPC_OP: begin
                rf_we = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000)      rf_wdata = rs1_val + rs2_val;
                        else if (funct7 == 7'b0100000) rf_wdata = rs1_val - rs2_val;
                        else                           rf_we = 1'b0;
                    end
                    3'b001: begin
                        rf_wdata = rs1_val << rs2_val[4:0];
                        rf_we    = (funct7 == 7'b0000000);
                    end
                    3'b010: begin
                        rf_wdata = {31'b0, $signed(rs1_val) < $signed(rs2_val)};
                        rf_we    = (funct7 == 7'b0000000);
                    end
                    3'b100: begin
                        rf_wdata = rs1_val ^ rs2_val;
                        rf_we    = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000)      rf_wdata = rs1_val >> rs2_val[4:0];
                        else if (funct7 == 7'b0100000) rf_wdata = $unsigned($signed(rs1_val) >>> rs2_val[4:0]);
                        else                           rf_we = 1'b0;
                    end
                    3'b110: begin
                        rf_wdata = rs1_val | rs2_val;
                        rf_we    = (funct7 == 7'b0000000);
                    end
                    3'b111: begin
                        rf_wdata = rs1_val & rs2_val;
                        rf_we    = (funct7 == 7'b0000000);
                    end
                    default: rf_we = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                rf_we    = (funct3 == 3'b000);
                rf_wdata = rs1_val + imm_i;
            end
            OPC_LUI: begin
                rf_we    = 1'b1;
                rf_wdata = imm_u;
            end
            OPC_AUIPC: begin
                rf_we    = 1'b1;
                rf_wdata = pc_q + imm_u;
            end
            OPC_JAL: begin
                rf_we    = 1'b1;
                rf_wdata = pc_plus4;
                pc_d     = pc_q + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    rf_we    = 1'b1;
                    rf_wdata = pc_plus4;
                    pc_d     = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                if (br_taken) pc_d = pc_q + imm_b;
            end
            OPC_LOAD: begin
                rf_we    = (funct3 == 3'b010);
                rf_wdata = dmem_q[load_addr[9:2]];
            end
            OPC_STORE: begin
                dm_we = (funct3 == 3'b010);
            end
            default: ;
        endcase
        if (rd == 5'd0) rf_we = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
            for (int i = 0; i < 32; i++)  regs_q[i] <= '0;
            for (int i = 0; i < 256; i++) dmem_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (rf_we) regs_q[rf_waddr] <= rf_wdata;
            if (dm_we) dmem_q[dm_waddr] <= dm_wdata;
        end
    end
endmodule

// File: tb/tb_risc_v.sv
// tb/tb_risc_v.sv - directed self-checking bench for the risc_v core
module tb_risc_v;
    logic        clk;
    logic        rst;
    logic [31:0] mem_input [0:255];

    int tests;
    int fails;

    risc_v dut (
        .clk       (clk),
        .rst       (rst),
        .mem_input (mem_input)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) mem_input[i] = 32'h0;

        mem_input[0]  = enc_i(32'd10, 5'd0, 3'b000, 5'd2, 7'b0010011);   // addi x2,x0,10
        mem_input[1]  = enc_i(32'd20, 5'd0, 3'b000, 5'd3, 7'b0010011);   // addi x3,x0,20
        mem_input[2]  = enc_r(7'h00, 5'd3, 5'd2, 3'b000, 5'd4);           // add  x4
        mem_input[3]  = enc_r(7'h20, 5'd2, 5'd3, 3'b000, 5'd5);           // sub  x5
        mem_input[4]  = enc_r(7'h00, 5'd3, 5'd2, 3'b111, 5'd6);           // and  x6
        mem_input[5]  = enc_r(7'h00, 5'd3, 5'd2, 3'b110, 5'd7);           // or   x7
        mem_input[6]  = enc_r(7'h00, 5'd3, 5'd2, 3'b100, 5'd8);           // xor  x8
        mem_input[7]  = enc_r(7'h00, 5'd3, 5'd2, 3'b001, 5'd9);           // sll  x9,x2,x3
        mem_input[8]  = enc_r(7'h00, 5'd2, 5'd3, 3'b101, 5'd10);          // srl  x10,x3,x2
        mem_input[9]  = enc_r(7'h20, 5'd2, 5'd3, 3'b101, 5'd11);          // sra  x11,x3,x2
        mem_input[10] = enc_r(7'h00, 5'd3, 5'd2, 3'b010, 5'd12);          // slt  x12,x2,x3
        mem_input[11] = enc_b(32'd8, 5'd3, 5'd2, 3'b000);                 // beq x2,x3,+8 (not taken)
        mem_input[12] = enc_j(32'd8, 5'd1);                               // jal x1,+8 at 48
        mem_input[13] = enc_i(32'd1, 5'd0, 3'b000, 5'd20, 7'b0010011);   // skipped
        mem_input[14] = enc_u(20'h00010, 5'd14, 7'b0010111);              // auipc x14,0x10 at 56
        mem_input[15] = enc_u(20'h12345, 5'd13, 7'b0110111);              // lui x13
        mem_input[16] = enc_s(32'd0, 5'd4, 5'd0);                         // sw x4,0(x0)
        mem_input[17] = enc_i(32'd0, 5'd0, 3'b010, 5'd15, 7'b0000011);   // lw x15,0(x0)
        mem_input[18] = enc_i(32'd5, 5'd0, 3'b000, 5'd0, 7'b0010011);    // addi x0,x0,5
        mem_input[19] = enc_i(32'hFFFFFF00, 5'd0, 3'b000, 5'd16, 7'b0010011); // addi x16,x0,-256
        mem_input[20] = enc_i(32'd4, 5'd0, 3'b000, 5'd17, 7'b0010011);   // addi x17,x0,4
        mem_input[21] = enc_r(7'h20, 5'd17, 5'd16, 3'b101, 5'd18);        // sra x18,x16,x17
        mem_input[22] = enc_b(32'd8, 5'd5, 5'd2, 3'b000);                 // beq x2,x5,+8 (taken)
        mem_input[23] = enc_i(32'd2, 5'd0, 3'b000, 5'd20, 7'b0010011);   // skipped
        mem_input[24] = enc_i(32'd108, 5'd0, 3'b000, 5'd1, 7'b0010011);  // addi x1,x0,108
        mem_input[25] = enc_i(32'd0, 5'd1, 3'b000, 5'd0, 7'b1100111);    // jalr x0,x1,0
        mem_input[26] = enc_i(32'd3, 5'd0, 3'b000, 5'd20, 7'b0010011);   // skipped
        mem_input[27] = enc_r(7'h00, 5'd2, 5'd16, 3'b010, 5'd19);         // slt x19,x16,x2 (signed)
        mem_input[28] = enc_b(32'd8, 5'd3, 5'd2, 3'b001);                 // bne x2,x3,+8
        mem_input[29] = 32'h0000_0000;                                    // unsupported opcode
        mem_input[30] = enc_j(32'd0, 5'd0);                               // jal x0,0 (spin)

        rst = 1'b0;
        #2;
        chk("reset_pc", dut.pc_q, 32'd0);
        chk("reset_x2", dut.regs_q[2], 32'd0);
        #10;
        rst = 1'b1;

        step; chk("addi_x2", dut.regs_q[2], 32'd10);
        step; chk("addi_x3", dut.regs_q[3], 32'd20);
        step; chk("add_x4", dut.regs_q[4], 32'd30);
        step; chk("sub_x5", dut.regs_q[5], 32'd10);
        step; chk("and_x6", dut.regs_q[6], 32'd0);
        step; chk("or_x7", dut.regs_q[7], 32'd30);
        step; chk("xor_x8", dut.regs_q[8], 32'd30);
        step; chk("sll_x9", dut.regs_q[9], 32'h00A0_0000);
        step; chk("srl_x10", dut.regs_q[10], 32'd0);
        step; chk("sra_x11", dut.regs_q[11], 32'd0);
        step; chk("slt_x12", dut.regs_q[12], 32'd1);
        chk("pc_before_beq", dut.pc_q, 32'd44);
        step; chk("beq_not_taken_pc", dut.pc_q, 32'd48);
        step; chk("jal_x1", dut.regs_q[1], 32'd52);
        chk("jal_pc", dut.pc_q, 32'd56);
        step; chk("auipc_x14", dut.regs_q[14], 32'h0001_0038);
        chk("jal_skip_x20", dut.regs_q[20], 32'd0);
        step; chk("lui_x13", dut.regs_q[13], 32'h1234_5000);
        step; chk("sw_dmem0", dut.dmem_q[0], 32'd30);
        step; chk("lw_x15", dut.regs_q[15], 32'd30);
        step; chk("x0_stays_zero", dut.regs_q[0], 32'd0);
        step; chk("addi_neg_x16", dut.regs_q[16], 32'hFFFF_FF00);
        step; chk("addi_x17", dut.regs_q[17], 32'd4);
        step; chk("sra_neg_x18", dut.regs_q[18], 32'hFFFF_FFF0);
        step; chk("beq_taken_pc", dut.pc_q, 32'd96);
        step; chk("addi_x1", dut.regs_q[1], 32'd108);
        step; chk("jalr_pc", dut.pc_q, 32'd108);
        chk("jalr_x1_kept", dut.regs_q[1], 32'd108);
        chk("branch_skip_x20", dut.regs_q[20], 32'd0);
        step; chk("slt_signed_x19", dut.regs_q[19], 32'd1);
`ifdef RISC_V_FULL_BRANCH_EN
        step; chk("bne_taken_pc", dut.pc_q, 32'd120);
`else
        step; chk("bne_as_nop_pc", dut.pc_q, 32'd116);
        step; chk("unsupported_nop_pc", dut.pc_q, 32'd120);
`endif
        step; chk("spin_pc", dut.pc_q, 32'd120);
        step; chk("spin_pc_again", dut.pc_q, 32'd120);

        // Mid-cycle asynchronous reset pulse.
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_pc", dut.pc_q, 32'd0);
        chk("async_reset_x2", dut.regs_q[2], 32'd0);
        chk("async_reset_x4", dut.regs_q[4], 32'd0);
        chk("async_reset_dmem0", dut.dmem_q[0], 32'd0);
        #12;
        rst = 1'b1;
        step; chk("restart_x2", dut.regs_q[2], 32'd10);
        chk("restart_pc", dut.pc_q, 32'd4);
        step; chk("restart_x3", dut.regs_q[3], 32'd20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
